sfx_player: RTL
===============

SFX_PLAYER -- requirements
Module: sfx_player

Interface
REQ-001 The module SHALL have the following parameters, one per line: name, default, meaning.
- TICK_DIV, 50000, clock cycles per 1 ms duration tick.
- HP_A5, 28409, half-period in clk cycles for the NEW tone.
- HP_C5, 47801, half-period for tone C.
- HP_E5, 37936, half-period for tone E.
- HP_G5, 31888, half-period for tone G.
- HP_C4, 95420, half-period for the low C tone.
- LEN_NEW, 30, NEW note length in ticks.
- LEN_CLR, 60, CLR note length in ticks.
- LEN_OVER, 150, OVER note length in ticks.
- GAP_LEN, 10, silent gap between notes in ticks.

REQ-002 The module SHALL have the following ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock (50 MHz nominal).
- rst, in, 1, asynchronous active-high reset.
- ev_new, in, 1, 1-cycle pulse: new piece generated.
- ev_clr, in, 1, 1-cycle pulse: row clear finished.
- ev_over, in, 1, game-over level; its rising edge is the event.
- mute, in, 1, level; forces beep low while sequencing continues.
- beep, out, 1, square-wave audio, high-active.
- busy, out, 1, high while an effect plays.
- effect, out, 2, current effect: 0 none, 1 NEW, 2 CLR, 3 OVER.

REQ-003 The module SHALL use one clock and an asynchronous, active-high reset (rst); all state SHALL be clocked on the rising edge of clk.

Function
REQ-004 Effects SHALL be played as fixed note sequences:
- NEW = [A5] at LEN_NEW.
- CLR = [C5, E5, G5] at LEN_CLR each.
- OVER = [G5, E5, C5, C4] at LEN_OVER each.

REQ-005 The FSM SHALL have three states: IDLE, PLAY and GAP.
- IDLE -> PLAY on an accepted event.
- PLAY -> GAP when the note ends and it is not the last note.
- PLAY -> IDLE when the last note ends.
- GAP -> PLAY, at the next note index, after GAP_LEN*TICK_DIV cycles.

REQ-006 Event priority SHALL be OVER > CLR > NEW; simultaneous events SHALL select the highest priority and discard the others.

REQ-007 An event SHALL be accepted in IDLE, or in PLAY/GAP only if its priority is strictly higher than effect; equal- or lower-priority events during play SHALL be discarded, not queued.

REQ-008 ev_over SHALL be edge-detected with a registered copy; a level held high SHALL trigger exactly once.

REQ-009 On acceptance at edge t, the following SHALL hold from edge t+1:
- state=PLAY, note index=0, effect=new code and busy=1.
- The tone counter and the tick counters SHALL be cleared, and beep SHALL be 1.
- Preemption SHALL behave identically: the old sequence is abandoned immediately.

REQ-010 In PLAY, the tone counter SHALL count 0..HP-1; on reaching HP-1 it SHALL wrap to 0 and beep SHALL toggle.

REQ-011 PLAY for a note SHALL last exactly LEN*TICK_DIV cycles, and GAP SHALL last exactly GAP_LEN*TICK_DIV cycles.

REQ-012 In GAP and IDLE, the internal beep register SHALL be 0, and each entry to PLAY SHALL restart the tone with beep=1 and tone counter=0.

REQ-013 On the edge ending the last note, the module SHALL set state=IDLE, busy=0, effect=0 and beep=0 in the same cycle.

REQ-014 The output beep SHALL equal the internal beep register AND NOT mute (combinational gating); mute SHALL NOT alter timing.

REQ-015 Counters SHALL be sized from the parameters:
- Tone counter SHALL be ceil(log2(max HP)) bits.
- Tick counter SHALL be ceil(log2(TICK_DIV)) bits.
- The ms counter SHALL be ceil(log2(max LEN)) bits.
- No counter SHALL overflow for the default values.

Reset
REQ-016 While rst is high, the module SHALL hold the following, and the first event SHALL be accepted on the first edge after rst deasserts:
- state=IDLE, beep=0, busy=0, effect=0, all counters 0.
- The ev_over edge register SHALL be 0.

REQ-017 Assertion of rst mid-effect SHALL force beep=0 and busy=0 asynchronously, with no resumption after release.

Verification
All scenarios below use TICK_DIV=4, HP_A5=3, HP_C5=5, HP_E5=4, HP_G5=3, HP_C4=6, LEN_NEW=3, LEN_CLR=2, LEN_OVER=2, GAP_LEN=1.

REQ-018 NEW timing: ev_new pulse at edge 0 -> the following SHALL be observed:
- busy=1 and effect=1 over edges 1..12.
- beep SHALL be 1 at edges 1-3, 0 at 4-6, 1 at 7-9 and 0 at 10-12.
- busy=0 and beep=0 SHALL hold at edge 13.

REQ-019 CLR sequence: ev_clr pulse -> the following SHALL be observed:
- 8 cycles at half-period 5, then 4 silent cycles.
- 8 cycles at half-period 4, then 4 silent cycles.
- 8 cycles at half-period 3, then idle.
- Total busy SHALL be 32 cycles.

REQ-020 Priority: ev_new and ev_clr in the same cycle -> effect=2; ev_new during CLR -> ignored, with busy duration unchanged at 32.

REQ-021 Preemption and edge detect: ev_over rises mid-CLR and is held high -> the following SHALL be observed:
- Next edge: effect=3, beep=1 and tone counter=0.
- The OVER sequence SHALL play once, with busy=1 for 4*8+3*4=44 cycles.
- After the sequence there SHALL be no retrigger while ev_over stays high.

REQ-022 Mute and reset: mute=1 during NEW -> beep stays 0 and busy still falls at edge 13; rst asserted mid-OVER -> beep=0 and busy=0 immediately, and the module stays IDLE after release.

Source files
------------

// File: rtl/sfx_player.sv
// Sound-effect sequencer: plays fixed square-wave note sequences for NEW / CLR / OVER events.
// Higher-priority events preempt the running effect at once; mute gates beep without touching timing.
module sfx_player #(
    parameter int TICK_DIV = 50000,
    parameter int HP_A5    = 28409,
    parameter int HP_C5    = 47801,
    parameter int HP_E5    = 37936,
    parameter int HP_G5    = 31888,
    parameter int HP_C4    = 95420,
    parameter int LEN_NEW  = 30,
    parameter int LEN_CLR  = 60,
    parameter int LEN_OVER = 150,
    parameter int GAP_LEN  = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ev_new,
    input  logic       ev_clr,
    input  logic       ev_over,
    input  logic       mute,
    output logic       beep,
    output logic       busy,
    output logic [1:0] effect
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int HP_MAX  = max2(max2(max2(HP_A5, HP_C5), max2(HP_E5, HP_G5)), HP_C4);
    localparam int LEN_MAX = max2(max2(LEN_NEW, LEN_CLR), max2(LEN_OVER, GAP_LEN));
    localparam int TONE_W  = max2($clog2(HP_MAX), 1);
    localparam int TICK_W  = max2($clog2(TICK_DIV), 1);
    localparam int MS_W    = max2($clog2(LEN_MAX), 1);

    localparam logic [TICK_W-1:0] TICK_M1 = TICK_W'(TICK_DIV - 1);
    localparam logic [MS_W-1:0]   GAP_M1  = MS_W'(GAP_LEN - 1);

    localparam logic [1:0] FX_NONE = 2'd0;
    localparam logic [1:0] FX_NEW  = 2'd1;
    localparam logic [1:0] FX_CLR  = 2'd2;
    localparam logic [1:0] FX_OVER = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        effect_q, effect_d;
    logic [1:0]        note_q, note_d;
    logic [TONE_W-1:0] tone_q, tone_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [MS_W-1:0]   ms_q, ms_d;
    logic              beep_q, beep_d;
    logic              over_q;

    logic [1:0]        req;
    logic              accept;
    logic              tick_end;
    logic [TONE_W-1:0] hp_m1;
    logic [MS_W-1:0]   len_m1;
    logic [1:0]        last_idx;

    // Priority encode; ev_over counts only on its rising edge.
    always_comb begin
        req = FX_NONE;
        if (ev_over && !over_q) begin
            req = FX_OVER;
        end else if (ev_clr) begin
            req = FX_CLR;
        end else if (ev_new) begin
            req = FX_NEW;
        end
    end

    // effect_q is FX_NONE whenever idle, so one compare covers both idle acceptance and preemption.
    assign accept   = (req > effect_q);
    assign tick_end = (tick_q == TICK_M1);

    always_comb begin
        hp_m1    = TONE_W'(HP_A5 - 1);
        len_m1   = MS_W'(LEN_NEW - 1);
        last_idx = 2'd0;
        case (effect_q)
            FX_CLR: begin
                len_m1   = MS_W'(LEN_CLR - 1);
                last_idx = 2'd2;
                case (note_q)
                    2'd0:    hp_m1 = TONE_W'(HP_C5 - 1);
                    2'd1:    hp_m1 = TONE_W'(HP_E5 - 1);
                    default: hp_m1 = TONE_W'(HP_G5 - 1);
                endcase
            end
            FX_OVER: begin
                len_m1   = MS_W'(LEN_OVER - 1);
                last_idx = 2'd3;
                case (note_q)
                    2'd0:    hp_m1 = TONE_W'(HP_G5 - 1);
                    2'd1:    hp_m1 = TONE_W'(HP_E5 - 1);
                    2'd2:    hp_m1 = TONE_W'(HP_C5 - 1);
                    default: hp_m1 = TONE_W'(HP_C4 - 1);
                endcase
            end
            default: begin
                hp_m1    = TONE_W'(HP_A5 - 1);
                len_m1   = MS_W'(LEN_NEW - 1);
                last_idx = 2'd0;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        effect_d = effect_q;
        note_d   = note_q;
        tone_d   = tone_q;
        tick_d   = tick_q;
        ms_d     = ms_q;
        beep_d   = beep_q;

        if (accept) begin
            state_d  = S_PLAY;
            effect_d = req;
            note_d   = 2'd0;
            tone_d   = '0;
            tick_d   = '0;
            ms_d     = '0;
            beep_d   = 1'b1;
        end else begin
            case (state_q)
                S_PLAY: begin
                    if (tick_end) begin
                        tick_d = '0;
                        ms_d   = ms_q + MS_W'(1);
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                    if (tone_q == hp_m1) begin
                        tone_d = '0;
                        beep_d = ~beep_q;
                    end else begin
                        tone_d = tone_q + TONE_W'(1);
                    end
                    if (tick_end && (ms_q == len_m1)) begin
                        tick_d = '0;
                        ms_d   = '0;
                        tone_d = '0;
                        beep_d = 1'b0;
                        if (note_q == last_idx) begin
                            state_d  = S_IDLE;
                            effect_d = FX_NONE;
                            note_d   = 2'd0;
                        end else begin
                            state_d = S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    beep_d = 1'b0;
                    if (tick_end) begin
                        tick_d = '0;
                        ms_d   = ms_q + MS_W'(1);
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                    // Each new note restarts its tone from the high phase.
                    if (tick_end && (ms_q == GAP_M1)) begin
                        state_d = S_PLAY;
                        note_d  = note_q + 2'd1;
                        tick_d  = '0;
                        ms_d    = '0;
                        tone_d  = '0;
                        beep_d  = 1'b1;
                    end
                end
                default: begin
                    state_d  = S_IDLE;
                    effect_d = FX_NONE;
                    note_d   = 2'd0;
                    tone_d   = '0;
                    tick_d   = '0;
                    ms_d     = '0;
                    beep_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            effect_q <= FX_NONE;
            note_q   <= 2'd0;
            tone_q   <= '0;
            tick_q   <= '0;
            ms_q     <= '0;
            beep_q   <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            effect_q <= effect_d;
            note_q   <= note_d;
            tone_q   <= tone_d;
            tick_q   <= tick_d;
            ms_q     <= ms_d;
            beep_q   <= beep_d;
            over_q   <= ev_over;
        end
    end

    assign beep   = beep_q & ~mute;
    assign busy   = (state_q != S_IDLE);
    assign effect = effect_q;

endmodule
